// File: rtl/cpu_mem_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and data access.
// Data has priority with a streak limit; an in-order ID FIFO routes responses back.
module cpu_mem_arbiter #(
   parameter int unsigned OUTSTANDING     = 4,
   parameter int unsigned MAX_DATA_STREAK = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        protocol_err
);

   localparam int unsigned PW = $clog2(OUTSTANDING);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

   state_t                 state, state_nxt;
   logic                   own_i, own_d, owner_req, accept, pop, head, full, streak_max;
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          count;
   logic [SW-1:0]          streak;
   logic [OUTSTANDING-1:0] fifo;

   assign full       = (count == CW'(OUTSTANDING));
   assign streak_max = (streak == SW'(MAX_DATA_STREAK));
   assign head       = fifo[rd_ptr];
   assign pop        = resetn & mem_data_ok & (count != '0);

   // Owner selection, grant hold under back-pressure, and request mux
   always_comb begin
      state_nxt    = state;
      own_i        = 1'b0;
      own_d        = 1'b0;
      mem_wr       = 1'b0;
      mem_size     = 2'd0;
      mem_addr     = 32'd0;
      mem_wdata    = 32'd0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      case (state)
         IDLE: begin
            own_d = data_req & ~(inst_req & streak_max);
            own_i = ~own_d & inst_req;
         end
         HOLD_I:  own_i = 1'b1;
         HOLD_D:  own_d = 1'b1;
         default: ;
      endcase
      owner_req = (own_i & inst_req) | (own_d & data_req);
      mem_req   = resetn & ~full & owner_req;
      accept    = mem_req & mem_addr_ok;
      case (state)
         IDLE:           if (mem_req && !mem_addr_ok) state_nxt = own_d ? HOLD_D : HOLD_I;
         HOLD_I, HOLD_D: if (!owner_req || accept) state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
      if (own_d) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end else if (own_i) begin
         mem_wr    = inst_wr;
         mem_size  = inst_size;
         mem_addr  = inst_addr;
         mem_wdata = inst_wdata;
      end
      inst_addr_ok = accept & own_i;
      data_addr_ok = accept & own_d;
   end

   assign inst_data_ok = pop & ~head;
   assign data_data_ok = pop & head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // ID FIFO, occupancy, streak and sticky error
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fifo         <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         streak       <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (accept) begin
            fifo[wr_ptr] <= own_d;
            wr_ptr       <= wr_ptr + PW'(1);
            if (own_d && inst_req) streak <= streak_max ? streak : streak + SW'(1);
            else                   streak <= '0;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (mem_data_ok && count == '0) protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: priority/streak, hold, routing, full and reset.
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, protocol_err;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpu_mem_arbiter #(.OUTSTANDING(4), .MAX_DATA_STREAK(3)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .protocol_err(protocol_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      resetn = 0;
      nxt();
      resetn = 1;
   endtask

   logic ids [9];
   logic exp_i;

   initial begin
      clr_inputs();
      resetn = 0;
      #12;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_perr", 32'(protocol_err), 0);
      chk("rst_count", 32'(dut.count), 0);
      nxt();
      resetn = 1;

      // reset mid-stream with three outstanding
      data_req = 1; data_addr = 32'h100; mem_addr_ok = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fill_d_addr_ok", 32'(data_addr_ok), 1);
         nxt();
      end
      data_req = 0;
      @(negedge clk);
      chk("fill_count3", 32'(dut.count), 3);
      nxt();
      resetn = 0; data_req = 1; mem_data_ok = 1;
      @(negedge clk);
      chk("midrst_mem_req", 32'(mem_req), 0);
      chk("midrst_d_addr_ok", 32'(data_addr_ok), 0);
      chk("midrst_d_data_ok", 32'(data_data_ok), 0);
      chk("midrst_i_data_ok", 32'(inst_data_ok), 0);
      chk("midrst_count", 32'(dut.count), 0);
      nxt();
      resetn = 1; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      @(negedge clk);
      chk("empty_d_data_ok", 32'(data_data_ok), 0);
      chk("empty_i_data_ok", 32'(inst_data_ok), 0);
      chk("perr_before", 32'(protocol_err), 0);
      nxt();
      mem_data_ok = 0;
      @(negedge clk);
      chk("perr_sticky", 32'(protocol_err), 1);
      nxt();
      @(negedge clk);
      chk("perr_held", 32'(protocol_err), 1);
      nxt();

      // streak: D,D,D,I,D,D,D,I with responses one cycle later
      do_reset();
      @(negedge clk);
      chk("perr_cleared", 32'(protocol_err), 0);
      chk("noown_addr", mem_addr, 0);
      nxt();
      inst_req = 1; inst_addr = 32'hA0; data_req = 1; data_addr = 32'hB0; mem_addr_ok = 1;
      for (int k = 0; k < 8; k++) begin
         exp_i = (k % 4 == 3);
         mem_data_ok = (k > 0);
         @(negedge clk);
         chk("streak_i_addr_ok", 32'(inst_addr_ok), 32'(exp_i));
         chk("streak_d_addr_ok", 32'(data_addr_ok), 32'(!exp_i));
         chk("streak_mem_addr", mem_addr, exp_i ? 32'hA0 : 32'hB0);
         if (k > 0) begin
            chk("streak_i_data_ok", 32'(inst_data_ok), 32'((k - 1) % 4 == 3));
            chk("streak_d_data_ok", 32'(data_data_ok), 32'((k - 1) % 4 != 3));
         end
         nxt();
      end

      // data held under back-pressure while inst arrives
      do_reset();
      data_req = 1; data_addr = 32'h1000; mem_addr_ok = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin inst_req = 1; inst_addr = 32'h2000; end
         if (k == 3) mem_addr_ok = 1;
         @(negedge clk);
         chk("hold_d_mem_addr", mem_addr, 32'h1000);
         chk("hold_d_i_addr_ok", 32'(inst_addr_ok), 0);
         chk("hold_d_d_addr_ok", 32'(data_addr_ok), 32'(k == 3));
         nxt();
      end

      // inst grant held even though data would win in IDLE
      do_reset();
      inst_req = 1; inst_addr = 32'h3000; mem_addr_ok = 0;
      @(negedge clk);
      chk("hold_i_mem_req", 32'(mem_req), 1);
      nxt();
      data_req = 1; data_addr = 32'h4000; mem_addr_ok = 1;
      @(negedge clk);
      chk("hold_i_mem_addr", mem_addr, 32'h3000);
      chk("hold_i_i_addr_ok", 32'(inst_addr_ok), 1);
      chk("hold_i_d_addr_ok", 32'(data_addr_ok), 0);
      nxt();
      inst_req = 0;
      @(negedge clk);
      chk("after_hold_d_addr_ok", 32'(data_addr_ok), 1);
      nxt();

      // response routing I, D, I
      do_reset();
      mem_addr_ok = 1;
      inst_req = 1; inst_addr = 32'hBFC00000;
      @(negedge clk);
      chk("rt_i0_addr_ok", 32'(inst_addr_ok), 1);
      chk("rt_i0_mem_addr", mem_addr, 32'hBFC00000);
      nxt();
      inst_req = 0; data_req = 1; data_addr = 32'h80000010;
      data_wr = 1; data_size = 2'd1; data_wdata = 32'hDEAD;
      @(negedge clk);
      chk("rt_d_addr_ok", 32'(data_addr_ok), 1);
      chk("rt_d_mem_wr", 32'(mem_wr), 1);
      chk("rt_d_mem_size", 32'(mem_size), 1);
      chk("rt_d_mem_wdata", mem_wdata, 32'hDEAD);
      nxt();
      data_req = 0; data_wr = 0; inst_req = 1; inst_addr = 32'hBFC00004;
      @(negedge clk);
      chk("rt_i1_addr_ok", 32'(inst_addr_ok), 1);
      chk("rt_i1_mem_addr", mem_addr, 32'hBFC00004);
      nxt();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11;
      @(negedge clk);
      chk("rt_r0_i_data_ok", 32'(inst_data_ok), 1);
      chk("rt_r0_d_data_ok", 32'(data_data_ok), 0);
      chk("rt_r0_rdata", inst_rdata, 32'h11);
      nxt();
      mem_rdata = 32'h22;
      @(negedge clk);
      chk("rt_r1_i_data_ok", 32'(inst_data_ok), 0);
      chk("rt_r1_d_data_ok", 32'(data_data_ok), 1);
      chk("rt_r1_rdata", data_rdata, 32'h22);
      nxt();
      mem_rdata = 32'h33;
      @(negedge clk);
      chk("rt_r2_i_data_ok", 32'(inst_data_ok), 1);
      chk("rt_r2_rdata", inst_rdata, 32'h33);
      nxt();
      mem_data_ok = 0;

      // full: 4 accepted, 5th blocked until the cycle after a pop
      do_reset();
      data_req = 1; data_addr = 32'h500; mem_addr_ok = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("full_fill_addr_ok", 32'(data_addr_ok), 1);
         nxt();
      end
      @(negedge clk);
      chk("full_mem_req", 32'(mem_req), 0);
      chk("full_addr_ok", 32'(data_addr_ok), 0);
      nxt();
      mem_data_ok = 1;
      @(negedge clk);
      chk("full_pop_mem_req", 32'(mem_req), 0);
      chk("full_pop_addr_ok", 32'(data_addr_ok), 0);
      chk("full_pop_data_ok", 32'(data_data_ok), 1);
      nxt();
      mem_data_ok = 0;
      @(negedge clk);
      chk("full_after_addr_ok", 32'(data_addr_ok), 1);
      nxt();
      data_req = 0;
      @(negedge clk);
      chk("full_after_count", 32'(dut.count), 4);
      nxt();

      // simultaneous push and pop at count 2
      do_reset();
      data_req = 1; mem_addr_ok = 1;
      nxt();
      nxt();
      mem_data_ok = 1;
      @(negedge clk);
      chk("pp_addr_ok", 32'(data_addr_ok), 1);
      chk("pp_data_ok", 32'(data_data_ok), 1);
      nxt();
      data_req = 0; mem_data_ok = 0;
      @(negedge clk);
      chk("pp_count", 32'(dut.count), 2);
      nxt();

      // nine transactions across pointer wrap
      do_reset();
      ids[0] = 0; ids[1] = 1; ids[2] = 1; ids[3] = 0; ids[4] = 1;
      ids[5] = 0; ids[6] = 0; ids[7] = 1; ids[8] = 1;
      mem_addr_ok = 1;
      for (int k = 0; k < 10; k++) begin
         inst_req = (k < 9) && !ids[k % 9];
         data_req = (k < 9) && ids[k % 9];
         inst_addr = 32'(k); data_addr = 32'(k);
         mem_data_ok = (k > 0);
         mem_rdata = 32'(k);
         @(negedge clk);
         if (k < 9) chk("wrap_addr_ok", 32'(inst_addr_ok | data_addr_ok), 1);
         if (k > 0) begin
            chk("wrap_i_data_ok", 32'(inst_data_ok), 32'(!ids[k - 1]));
            chk("wrap_d_data_ok", 32'(data_data_ok), 32'(ids[k - 1]));
         end
         nxt();
      end
      clr_inputs();
      @(negedge clk);
      chk("wrap_count", 32'(dut.count), 0);
      chk("wrap_perr", 32'(protocol_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
